// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, defaults and saturating add for the MAC engine
// Purpose: FSM state encoding, default widths, and the clamp/wrap helper used
//          for both product narrowing and accumulation.
// Ports:   none (package).
package mac_pkg;

    localparam int MAC_DW   = 16;
    localparam int MAC_FRAC = 8;
    localparam int MAC_AW   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Adds at 64 bits (wide enough that nothing overflows for DW <= 32).
    // The result is then either clamped to the signed dw-bit range or
    // wrapped to its low dw bits. In both cases it is returned sign-extended.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 dw,
        input bit                 sat
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        s  = a + b;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sat) begin
            if (s > hi) begin
                r = hi;
            end else if (s < lo) begin
                r = lo;
            end else begin
                r = s;
            end
        end else begin
            r = (s <<< (64 - dw)) >>> (64 - dw);
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined signed fixed-point multiplier
// Purpose: p_o = (a_i * b_i) >>> FRAC, full 2*DW width, MUL_LAT cycles after the
//          operands are presented. The pipeline carries data only and has no enable.
// Ports:   clk_i, rst_ni (async active-low), a_i/b_i signed operands,
//          p_o shifted product (floor division by 2^FRAC).
module mult_pipe
    import mac_pkg::*;
#(
    parameter int DW      = MAC_DW,
    parameter int FRAC    = MAC_FRAC,
    parameter int MUL_LAT = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [2*DW-1:0] p_o
);

    logic signed [2*DW-1:0] prod_full;
    logic signed [2*DW-1:0] prod_shift;
    logic signed [2*DW-1:0] p_q [MUL_LAT];

    // Sign-extend before multiplying so the full product is exact.
    // An arithmetic shift of a two's complement value rounds toward -inf.
    assign prod_full  = (2*DW)'(a_i) * (2*DW)'(b_i);
    assign prod_shift = prod_full >>> FRAC;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            p_q[0] <= prod_shift;
            for (int i = 1; i < MUL_LAT; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign p_o = p_q[MUL_LAT-1];

endmodule

// File: rtl/mac_acc_pipe.sv
// rtl/mac_acc_pipe.sv - pipelined multiply-accumulate into an external register file
// Purpose: each accepted sample/weight pair is multiplied and then added into
//          (or, with in_first, written over) a register-file entry. Stage R issues
//          the read at cycle MUL_LAT. Stage W writes at cycle MUL_LAT+1. A write in
//          stage W is forwarded to an adjacent read of the same address.
// Ports:   clk_i, rst_ni (async active-low)
//          in_valid_i/in_ready_o handshake; in_first_i, in_last_i, in_data_i,
//          in_weight_i, in_addr_i
//          rf_rd_en_o/rf_rd_addr_o and rf_rd_data_i (returned one cycle later)
//          rf_wr_en_o/rf_wr_addr_o/rf_wr_data_o
//          busy_o, done_o (1-cycle pulse), addr_err_o (sticky range error)
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int          DW      = MAC_DW,
    parameter int          FRAC    = MAC_FRAC,
    parameter int          AW      = MAC_AW,
    parameter int unsigned DEPTH   = 100,
    parameter int          MUL_LAT = 5,
    parameter bit          SAT     = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_first_i,
    input  logic          in_last_i,
    input  logic [DW-1:0] in_data_i,
    input  logic [DW-1:0] in_weight_i,
    input  logic [AW-1:0] in_addr_i,
    output logic          rf_rd_en_o,
    output logic [AW-1:0] rf_rd_addr_o,
    input  logic [DW-1:0] rf_rd_data_i,
    output logic          rf_wr_en_o,
    output logic [AW-1:0] rf_wr_addr_o,
    output logic [DW-1:0] rf_wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          addr_err_o
);

    state_t state_q;
    logic   in_ready_q;
    logic   busy_q;
    logic   done_q;
    logic   addr_err_q;

    logic accept;
    logic in_ok;

    // Side-band that travels alongside the multiplier. Index MUL_LAT-1 is stage R.
    logic [MUL_LAT-1:0] sb_valid_q;
    logic [MUL_LAT-1:0] sb_ok_q;
    logic [MUL_LAT-1:0] sb_first_q;
    logic [AW-1:0]      sb_addr_q [MUL_LAT];

    logic signed [2*DW-1:0] prod_full;
    logic signed [DW-1:0]   r_prod;
    logic                   r_rd;
    logic [AW-1:0]          r_addr;

    // Stage W
    logic                 w_wr_q;
    logic                 w_first_q;
    logic [AW-1:0]        w_addr_q;
    logic signed [DW-1:0] w_prod_q;
    logic                 fwd_q;
    logic signed [DW-1:0] fwd_data_q;
    logic signed [DW-1:0] old_val;
    logic signed [DW-1:0] wr_data_d;

    assign accept = in_valid_i & in_ready_q;
    assign in_ok  = (32'(in_addr_i) < DEPTH);

    mult_pipe #(
        .DW      (DW),
        .FRAC    (FRAC),
        .MUL_LAT (MUL_LAT)
    ) u_mult (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .a_i    ($signed(in_data_i)),
        .b_i    ($signed(in_weight_i)),
        .p_o    (prod_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_valid_q <= '0;
            sb_ok_q    <= '0;
            sb_first_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                sb_addr_q[i] <= '0;
            end
        end else begin
            sb_valid_q[0] <= accept;
            sb_ok_q[0]    <= in_ok;
            sb_first_q[0] <= in_first_i;
            sb_addr_q[0]  <= in_addr_i;
            for (int i = 1; i < MUL_LAT; i++) begin
                sb_valid_q[i] <= sb_valid_q[i-1];
                sb_ok_q[i]    <= sb_ok_q[i-1];
                sb_first_q[i] <= sb_first_q[i-1];
                sb_addr_q[i]  <= sb_addr_q[i-1];
            end
        end
    end

    // Stage R. Out-of-range entries keep flowing but never touch the register file.
    assign r_rd   = sb_valid_q[MUL_LAT-1] & sb_ok_q[MUL_LAT-1];
    assign r_addr = sb_addr_q[MUL_LAT-1];
    assign r_prod = DW'(sat_add(64'(prod_full), 64'sd0, DW, SAT));

    assign rf_rd_en_o   = r_rd;
    assign rf_rd_addr_o = r_rd ? r_addr : '0;

    // A read and a write to the same entry on the same edge return stale data.
    // So the value being written now is captured for the entry that follows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_wr_q     <= 1'b0;
            w_first_q  <= 1'b0;
            w_addr_q   <= '0;
            w_prod_q   <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            w_wr_q     <= r_rd;
            w_first_q  <= sb_first_q[MUL_LAT-1];
            w_addr_q   <= r_addr;
            w_prod_q   <= r_prod;
            fwd_q      <= r_rd & w_wr_q & (r_addr == w_addr_q);
            fwd_data_q <= wr_data_d;
        end
    end

    assign old_val   = fwd_q ? fwd_data_q : $signed(rf_rd_data_i);
    assign wr_data_d = w_first_q ? w_prod_q
                                 : DW'(sat_add(64'(old_val), 64'(w_prod_q), DW, SAT));

    assign rf_wr_en_o   = w_wr_q;
    assign rf_wr_addr_o = w_wr_q ? w_addr_q : '0;
    assign rf_wr_data_o = w_wr_q ? wr_data_d : '0;

    // Control FSM. Stage W never needs checking for DRAIN exit: it finishes its
    // write on the same edge that returns the FSM to IDLE, so done follows the
    // last write by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (!in_ok) begin
                    addr_err_q <= 1'b1;
                end else if (in_first_i) begin
                    addr_err_q <= 1'b0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (in_last_i) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept && in_last_i) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (sb_valid_q == '0) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign addr_err_o = addr_err_q;

endmodule
